// File: rtl/serial_word_buffer_if.sv
// Host and engine side signals of serial_word_buffer. The buffer uses the slave modport.
// The host/engine side uses the master modport.
interface serial_word_buffer_if #(
    parameter int unsigned DEPTH_LOG2 = 3
);
    logic [63:0]         host_tx_data;
    logic                host_tx_valid;
    logic                host_tx_ready;
    logic [63:0]         host_rx_data;
    logic                host_rx_valid;
    logic                host_rx_ready;
    logic [DEPTH_LOG2:0] tx_level;
    logic [DEPTH_LOG2:0] rx_level;
    logic [63:0]         uart_data_in;
    logic                uart_enable_write;
    logic                uart_busy_write;
    logic [63:0]         uart_data_out;
    logic                uart_data_avail;
    logic                uart_enable_read;

    modport slave (
        input  host_tx_data, host_tx_valid, host_rx_ready,
        input  uart_busy_write, uart_data_out, uart_data_avail,
        output host_tx_ready, host_rx_data, host_rx_valid, tx_level, rx_level,
        output uart_data_in, uart_enable_write, uart_enable_read
    );

    modport master (
        output host_tx_data, host_tx_valid, host_rx_ready,
        output uart_busy_write, uart_data_out, uart_data_avail,
        input  host_tx_ready, host_rx_data, host_rx_valid, tx_level, rx_level,
        input  uart_data_in, uart_enable_write, uart_enable_read
    );
endinterface

// File: rtl/serial_word_buffer.sv
// TX and RX word FIFOs between the host channel and the uart64 word engine.
// Each FIFO is serviced on the engine side by its own small handshake FSM.
module serial_word_buffer #(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input logic                 clk,
    input logic                 rst,
    serial_word_buffer_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [LW-1:0]         lvl_t;

    localparam lvl_t FULL = lvl_t'(DEPTH);

    typedef enum logic [1:0] {TxIdle, TxIssue, TxArm, TxBusy} tx_state_e;
    typedef enum logic {RxIdle, RxDrain} rx_state_e;

    tx_state_e   tx_state_q;
    rx_state_e   rx_state_q;

    logic [63:0] tx_mem [DEPTH];
    ptr_t        tx_wr_q;
    ptr_t        tx_rd_q;
    lvl_t        tx_level_q;
    lvl_t        tx_level_d;
    logic        tx_ready_q;
    logic        tx_push;
    logic        tx_pop;
    logic [63:0] uart_data_q;
    logic        enable_write_q;

    logic [63:0] rx_mem [DEPTH];
    ptr_t        rx_wr_q;
    ptr_t        rx_rd_q;
    ptr_t        rx_rd_next;
    lvl_t        rx_level_q;
    lvl_t        rx_level_d;
    logic        rx_valid_q;
    logic [63:0] rx_data_q;
    logic        rx_write;
    logic        rx_pop;
    logic        enable_read_q;

    // ---------------------------------------------------------------- TX side
    assign tx_push = bus.host_tx_valid && tx_ready_q;
    assign tx_pop  = (tx_state_q == TxIdle) && (tx_level_q != '0);

    always_comb begin
        tx_level_d = tx_level_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_level_d = tx_level_q + 1'b1;
            2'b01:   tx_level_d = tx_level_q - 1'b1;
            default: tx_level_d = tx_level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_level_q <= '0;
            tx_ready_q <= 1'b1;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
            tx_level_q <= tx_level_d;
            tx_ready_q <= (tx_level_d != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q] <= bus.host_tx_data;
    end

    // busy_write lags the strobe by two cycles, so TxArm waits for it to rise
    // before TxBusy can trust a low level as "done".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q     <= TxIdle;
            uart_data_q    <= '0;
            enable_write_q <= 1'b0;
        end else begin
            enable_write_q <= 1'b0;
            case (tx_state_q)
                TxIdle: begin
                    if (tx_level_q != '0) begin
                        uart_data_q    <= tx_mem[tx_rd_q];
                        enable_write_q <= 1'b1;
                        tx_state_q     <= TxIssue;
                    end
                end
                TxIssue: tx_state_q <= TxArm;
                TxArm: begin
                    if (bus.uart_busy_write) tx_state_q <= TxBusy;
                end
                TxBusy: begin
                    if (!bus.uart_busy_write) tx_state_q <= TxIdle;
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end

    // ---------------------------------------------------------------- RX side
    assign rx_write   = (rx_state_q == RxIdle) && bus.uart_data_avail && (rx_level_q != FULL);
    assign rx_pop     = rx_valid_q && bus.host_rx_ready;
    assign rx_rd_next = rx_rd_q + 1'b1;

    always_comb begin
        rx_level_d = rx_level_q;
        case ({rx_write, rx_pop})
            2'b10:   rx_level_d = rx_level_q + 1'b1;
            2'b01:   rx_level_d = rx_level_q - 1'b1;
            default: rx_level_d = rx_level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_level_q <= '0;
        end else begin
            if (rx_write) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)   rx_rd_q <= rx_rd_next;
            rx_level_q <= rx_level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_write) rx_mem[rx_wr_q] <= bus.uart_data_out;
    end

    // The head register only looks at entries written on earlier edges, so a
    // word landing in an empty FIFO shows up one cycle after its write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else if (rx_pop) begin
            rx_valid_q <= (rx_level_q > lvl_t'(1));
            if (rx_level_q > lvl_t'(1)) rx_data_q <= rx_mem[rx_rd_next];
        end else begin
            rx_valid_q <= (rx_level_q != '0);
            if (rx_level_q != '0) rx_data_q <= rx_mem[rx_rd_q];
        end
    end

    // data_avail stays high for two cycles after the acknowledge; RxDrain
    // keeps the same word from being captured twice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q    <= RxIdle;
            enable_read_q <= 1'b0;
        end else begin
            enable_read_q <= 1'b0;
            case (rx_state_q)
                RxIdle: begin
                    if (rx_write) begin
                        enable_read_q <= 1'b1;
                        rx_state_q    <= RxDrain;
                    end
                end
                RxDrain: begin
                    if (!bus.uart_data_avail) rx_state_q <= RxIdle;
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    assign bus.host_tx_ready     = tx_ready_q;
    assign bus.tx_level          = tx_level_q;
    assign bus.uart_data_in      = uart_data_q;
    assign bus.uart_enable_write = enable_write_q;
    assign bus.host_rx_valid     = rx_valid_q;
    assign bus.host_rx_data      = rx_data_q;
    assign bus.rx_level          = rx_level_q;
    assign bus.uart_enable_read  = enable_read_q;
endmodule
